// File: rtl/decode_pkg.sv
// Package shared by the instruction-decode stage.
// Contents:
//   fmt_e         - instruction format code driven on the fmt output
//   opcode consts - RV32/RV64 base opcodes the stage recognises
//   dec_bundle_t  - decoded bundle held in the output and skid registers;
//                   pc/imm are sized for the widest XLEN and sliced by the user
//   classify()    - opcode -> format lookup
package decode_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } dec_bundle_t;

    // The word-sized opcodes exist only on RV64.
    function automatic fmt_e classify(input logic [6:0] opc, input logic rv64);
        case (opc)
            OP:                                      return FMT_R;
            OP_32:                                   return rv64 ? FMT_R : FMT_ILL;
            OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM:    return FMT_I;
            OP_IMM_32:                               return rv64 ? FMT_I : FMT_ILL;
            STORE:                                   return FMT_S;
            BRANCH:                                  return FMT_B;
            LUI, AUIPC:                              return FMT_U;
            JAL:                                     return FMT_J;
            default:                                 return FMT_ILL;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Handshake and bundle signals of the instruction-decode stage.
//   upstream  : in_valid, in_ready, in_instr, in_pc, flush
//   downstream: out_valid, out_ready, out_pc, opcode, rd, funct3, rs1, rs2,
//               funct7, fmt, imm, illegal
// Modports: master = the environment around the stage, slave = the stage.
interface instr_decode_stage_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2,
               funct7, fmt, imm, illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2,
               funct7, fmt, imm, illegal
    );
endinterface

// File: rtl/instr_decode_stage_imm_gen.sv
// imm_gen: combinational immediate assembly for the decode stage.
//   instr : instruction bits [31:7] (the opcode field carries no immediate bits)
//   fmt   : decoded format; R and ILL produce a zero immediate
//   imm   : immediate sign-extended from instr[31] to XLEN
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);
    // Every format fits in 32 bits; widening to XLEN is one shared step.
    logic [31:0] imm32;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // imm32 unassigned, which would otherwise infer a latch.
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    if (XLEN > 32) begin : g_wide
        assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
        assign imm = imm32;
    end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV instruction decode with valid/ready on
// both sides. Decode is combinational on the input side; the bundle lands in
// an output register (OR) one cycle after accept. A skid register (SK)
// absorbs the instruction accepted while OR is stalled, so in_ready can be a
// flop. flush empties both registers; reset is asynchronous, active-high.
//   clk, reset : clock (rising edge), async active-high reset
//   bus        : instr_decode_stage_if slave modport (handshakes + bundle)
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input logic                    clk,
    input logic                    reset,
    instr_decode_stage_if.slave    bus
);
    dec_bundle_t     dec, or_q, or_d, sk_q, sk_d;
    logic            or_v, or_v_d, sk_v, sk_v_d, in_ready_q;
    fmt_e            raw_fmt, dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic            accept, or_free;

    // ---- decode ----
    assign raw_fmt     = classify(bus.in_instr[6:0], XLEN == 64);
    assign dec_illegal = (bus.in_instr[1:0] != 2'b11) || (raw_fmt == FMT_ILL);
    assign dec_fmt     = dec_illegal ? FMT_ILL : raw_fmt;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (bus.in_instr[31:7]),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    always_comb begin
        dec                = '0;
        dec.pc[XLEN-1:0]   = bus.in_pc;
        dec.opcode         = bus.in_instr[6:0];
        dec.rd             = bus.in_instr[11:7];
        dec.funct3         = bus.in_instr[14:12];
        dec.rs1            = bus.in_instr[19:15];
        dec.rs2            = bus.in_instr[24:20];
        dec.funct7         = bus.in_instr[31:25];
        dec.fmt            = dec_fmt;
        dec.imm[XLEN-1:0]  = dec_imm;
        dec.illegal        = dec_illegal;
    end

    // ---- OR / SK next state ----
    assign accept  = bus.in_valid && in_ready_q;
    assign or_free = !or_v || bus.out_ready;

    always_comb begin
        or_d   = or_q;
        sk_d   = sk_q;
        or_v_d = or_v;
        sk_v_d = sk_v;
        if (bus.flush) begin
            or_v_d = 1'b0;
            sk_v_d = 1'b0;
        end else if (or_free) begin
            if (sk_v) begin
                // Older skid entry moves up first to keep program order.
                or_d   = sk_q;
                or_v_d = 1'b1;
                sk_v_d = accept;
                if (accept) sk_d = dec;
            end else begin
                or_v_d = accept;
                if (accept) or_d = dec;
            end
        end else if (accept) begin
            sk_d   = dec;
            sk_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data registers are reset too, because their contents
            // are visible on the outputs while out_valid is low.
            or_q       <= '0;
            or_q.pc    <= XLEN_MAX'(PC_RESET);
            sk_q       <= '0;
            or_v       <= 1'b0;
            sk_v       <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_v       <= or_v_d;
            sk_v       <= sk_v_d;
            in_ready_q <= !sk_v_d;
        end
    end

    // Upper halves of pc/imm are unused when XLEN is narrower than the bundle.
    if (XLEN < XLEN_MAX) begin : g_trunc
        logic unused_hi;
        assign unused_hi = ^{or_q.pc[XLEN_MAX-1:XLEN], or_q.imm[XLEN_MAX-1:XLEN]};
    end

    // ---- outputs ----
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = or_v;
    assign bus.out_pc    = or_q.pc[XLEN-1:0];
    assign bus.opcode    = or_q.opcode;
    assign bus.rd        = or_q.rd;
    assign bus.funct3    = or_q.funct3;
    assign bus.rs1       = or_q.rs1;
    assign bus.rs2       = or_q.rs2;
    assign bus.funct7    = or_q.funct7;
    assign bus.fmt       = or_q.fmt;
    assign bus.imm       = or_q.imm[XLEN-1:0];
    assign bus.illegal   = or_q.illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: an RV32 and an RV64 instance share
// one stimulus stream; outputs are sampled 1 time unit after each rising edge.
module tb_instr_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    int          n_vec = 0;
    int          n_bad = 0;

    logic [31:0] s_instr [4];
    logic [31:0] s_imm   [4];
    logic [2:0]  s_fmt   [4];
    logic [4:0]  s_rd    [4];
    logic [4:0]  s_rs1   [4];
    logic [4:0]  s_rs2   [4];

    instr_decode_stage_if #(.XLEN(32)) if32 ();
    instr_decode_stage_if #(.XLEN(64)) if64 ();

    assign if32.flush     = flush;
    assign if32.in_valid  = in_valid;
    assign if32.in_instr  = in_instr;
    assign if32.in_pc     = in_pc;
    assign if32.out_ready = out_ready;
    assign if64.flush     = flush;
    assign if64.in_valid  = in_valid;
    assign if64.in_instr  = in_instr;
    assign if64.in_pc     = {32'h0, in_pc};
    assign if64.out_ready = out_ready;

    instr_decode_stage #(.XLEN(32), .PC_RESET(32'h0000_1000)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32)
    );

    instr_decode_stage #(.XLEN(64), .PC_RESET(64'h0000_0000_8000_0000)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (if64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_instr = '{32'h00112623, 32'hFE000EE3, 32'h123452B7, 32'h001000EF};
        s_imm   = '{32'd12, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0800};
        s_fmt   = '{3'd2, 3'd3, 3'd4, 3'd5};
        s_rd    = '{5'd12, 5'd29, 5'd5, 5'd1};
        s_rs1   = '{5'd2, 5'd0, 5'd8, 5'd0};
        s_rs2   = '{5'd1, 5'd0, 5'd3, 5'd1};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        // ---- reset state ----
        tick(); tick();
        check("rst_ovalid32", if32.out_valid, 0);
        check("rst_ready32",  if32.in_ready, 1);
        check("rst_pc32",     if32.out_pc, 32'h1000);
        check("rst_imm32",    if32.imm, 0);
        check("rst_opcode32", if32.opcode, 0);
        check("rst_pc64",     if64.out_pc, 64'h8000_0000);
        #3 reset = 1'b0;

        // ---- single addi x1,x0,-1 ----
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h200; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("addi_ovalid", if32.out_valid, 1);
        check("addi_fmt",    if32.fmt, 3'd1);
        check("addi_rd",     if32.rd, 1);
        check("addi_rs1",    if32.rs1, 0);
        check("addi_imm",    if32.imm, 32'hFFFF_FFFF);
        check("addi_ill",    if32.illegal, 0);
        check("addi_pc",     if32.out_pc, 32'h200);
        tick();
        check("addi_drain", if32.out_valid, 0);

        // ---- back-to-back stream: sw, beq, lui, jal ----
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_instr = s_instr[k]; in_pc = 32'h300 + 32'(4 * k);
            tick();
            check("strm_ovalid", if32.out_valid, 1);
            check("strm_ready",  if32.in_ready, 1);
            check("strm_fmt",    if32.fmt, s_fmt[k]);
            check("strm_imm",    if32.imm, s_imm[k]);
            check("strm_rd",     if32.rd, s_rd[k]);
            check("strm_rs1",    if32.rs1, s_rs1[k]);
            check("strm_rs2",    if32.rs2, s_rs2[k]);
            check("strm_pc",     if32.out_pc, 32'h300 + 32'(4 * k));
        end
        in_valid = 1'b0;
        check("strm_funct3_jal", if32.funct3, 0);
        tick();
        check("strm_end", if32.out_valid, 0);

        // ---- backpressure: A into OR, B into SK, C refused, then drain ----
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
        tick();
        check("bp_a_imm",   if32.imm, 1);
        check("bp_a_ready", if32.in_ready, 1);
        out_ready = 1'b0; in_instr = 32'h00200113; in_pc = 32'h404;
        tick();
        check("bp_skfull_ready", if32.in_ready, 0);
        check("bp_hold_imm",     if32.imm, 1);
        in_instr = 32'h00300193; in_pc = 32'h408;
        tick();
        check("bp_stall_ready",  if32.in_ready, 0);
        check("bp_stall_valid",  if32.out_valid, 1);
        check("bp_stall_imm",    if32.imm, 1);
        check("bp_stall_pc",     if32.out_pc, 32'h400);
        out_ready = 1'b1;
        tick();
        check("bp_b_imm",   if32.imm, 2);
        check("bp_b_ready", if32.in_ready, 1);
        tick();
        check("bp_c_imm", if32.imm, 3);
        check("bp_c_pc",  if32.out_pc, 32'h408);
        in_instr = 32'h00400213; in_pc = 32'h40C;
        tick();
        check("bp_d_imm", if32.imm, 4);
        in_valid = 1'b0;
        tick();
        check("bp_end", if32.out_valid, 0);

        // ---- flush with OR and SK full and in_valid high ----
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500293;
        tick();
        in_instr = 32'h00600313;
        tick();
        check("fl_full_ready", if32.in_ready, 0);
        in_instr = 32'h00700393; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_ovalid", if32.out_valid, 0);
        check("fl_ready",  if32.in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("fl_gone1", if32.out_valid, 0);
        tick();
        check("fl_gone2", if32.out_valid, 0);
        // input accepted during a flush is discarded
        in_valid = 1'b1; in_instr = 32'h00500293; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_accept_drop", if32.out_valid, 0);

        // ---- illegal encodings ----
        in_valid = 1'b1; in_instr = 32'h00000000;
        tick();
        check("ill0_valid", if32.out_valid, 1);
        check("ill0_ill",   if32.illegal, 1);
        check("ill0_fmt",   if32.fmt, 3'd7);
        check("ill0_imm",   if32.imm, 0);
        check("ill0_ill64", if64.illegal, 1);
        in_instr = 32'h0000007F;
        tick();
        check("ill7f_ill",    if32.illegal, 1);
        check("ill7f_opcode", if32.opcode, 7'h7F);
        in_instr = 32'hFFF0001B;
        tick();
        check("w32_ill",   if32.illegal, 1);
        check("w32_imm",   if32.imm, 0);
        check("w64_ill",   if64.illegal, 0);
        check("w64_fmt",   if64.fmt, 3'd1);
        check("w64_imm",   if64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        in_instr = 32'h0000001B;
        tick();
        check("w32b_ill", if32.illegal, 1);
        check("w64b_fmt", if64.fmt, 3'd1);
        check("w64b_ill", if64.illegal, 0);
        // sign extension of U and B at XLEN=64
        in_instr = 32'h800000B7;
        tick();
        check("lui32_imm", if32.imm, 32'h8000_0000);
        check("lui64_imm", if64.imm, 64'hFFFF_FFFF_8000_0000);
        in_instr = 32'hFE000EE3;
        tick();
        check("beq64_imm", if64.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        in_valid = 1'b0;
        tick();

        // ---- async reset in the middle of a stall ----
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
        tick();
        in_instr = 32'h00200113;
        tick();
        in_valid = 1'b0;
        check("ar_pre_valid", if32.out_valid, 1);
        check("ar_pre_ready", if32.in_ready, 0);
        #2 reset = 1'b1;
        #1;
        check("ar_ovalid32", if32.out_valid, 0);
        check("ar_ready32",  if32.in_ready, 1);
        check("ar_pc32",     if32.out_pc, 32'h1000);
        check("ar_imm32",    if32.imm, 0);
        check("ar_ovalid64", if64.out_valid, 0);
        #3 reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h500;
        tick();
        in_valid = 1'b0;
        check("r64_valid", if64.out_valid, 1);
        check("r64_fmt",   if64.fmt, 3'd1);
        check("r64_imm",   if64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("r64_pc",    if64.out_pc, 64'h500);
        tick();
        check("r64_no_ghost", if32.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
